// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one forward round per clock with on-the-fly key expansion.
// Blocks enter on an in_valid/in_ready handshake; ciphertext is held on out_valid until out_ready.
module aes_encrypt_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out,
    output logic         busy
);

    if (NR != 10) begin : g_bad_nr
        $error("aes_encrypt_iter: only NR=10 (AES-128) is supported");
    end

    localparam logic [3:0] NR_L = NR[3:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       state_r, state_s;
    logic [127:0] st_r, rk_r, out_r;
    logic [127:0] rk_next_s, sr_s, round_s;
    logic [3:0]   rnd_r;
    logic         accept_s, last_s;
    logic         in_ready_r, out_valid_r, busy_r;
    logic         in_ready_s, out_valid_s, busy_s;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as a^254 (multiplicative inverse, 0 maps to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Byte (row w, column c) lives at bits [127-8*(4c+w) -: 8]
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127 - 8*(4*c + w) -: 8] = sbox(s[127 - 8*(4*((c + w) % 4) + w) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign accept_s = in_valid & in_ready_r;
    assign last_s   = (rnd_r == NR_L);

    // One cipher round; the final round skips mixColumns
    always_comb begin
        rk_next_s = expand_key(rk_r, rcon(rnd_r));
        sr_s      = sub_shift(st_r);
        if (last_s) begin
            round_s = sr_s ^ rk_next_s;
        end else begin
            round_s = mix_columns(sr_s) ^ rk_next_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: if (accept_s)  state_s = ST_RUN;  else state_s = ST_IDLE;
            ST_RUN:  if (last_s)    state_s = ST_DONE; else state_s = ST_RUN;
            ST_DONE: if (out_ready) state_s = ST_IDLE; else state_s = ST_DONE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the next state so the registered copies track the FSM
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b1;
        case (state_s)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            ST_DONE: out_valid_s = 1'b1;
            default: begin end
        endcase
    end

    // Round datapath, round counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_r        <= 128'h0;
            rk_r        <= 128'h0;
            out_r       <= 128'h0;
            rnd_r       <= 4'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        st_r  <= in ^ key;
                        rk_r  <= key;
                        rnd_r <= 4'd1;
                    end
                end
                ST_RUN: begin
                    st_r  <= round_s;
                    rk_r  <= rk_next_s;
                    rnd_r <= rnd_r + 4'd1;
                    if (last_s) out_r <= round_s;
                end
                default: begin end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out       = out_r;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: FIPS-197 vectors, handshake corner cases and
// randomized traffic compared every cycle against a table-driven AES and transaction model.
module tb_aes_encrypt_iter;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] din;
    logic [127:0] dkey;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dout;
    logic         busy;

    int errors = 0;
    int checks = 0;

    aes_encrypt_iter #(.NR(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .key       (dkey),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference AES (table S-box, full key schedule) ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h000000};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r + 4*c] = t[r + 4*((c + r) % 4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[4*c + r];
                    s[4*c+0] = xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3];
                    s[4*c+1] = a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3];
                    s[4*c+2] = a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3];
                    s[4*c+3] = xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3]);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- transaction model ----------------
    int           m_left;
    logic         m_ov, m_ir;
    logic [127:0] m_out, m_pending;
    int           n_left;
    logic         n_ov;
    logic         accept_m;

    assign accept_m = in_valid && m_ir;

    always_comb begin
        n_left = m_left;
        n_ov   = m_ov;
        if (accept_m) begin
            n_left = 10;
        end else if (m_left > 0) begin
            n_left = m_left - 1;
            if (m_left == 1) n_ov = 1'b1;
        end else if (m_ov && out_ready) begin
            n_ov = 1'b0;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left    <= 0;
            m_ov      <= 1'b0;
            m_ir      <= 1'b0;
            m_out     <= 128'h0;
            m_pending <= 128'h0;
        end else begin
            m_left <= n_left;
            m_ov   <= n_ov;
            m_ir   <= (n_left == 0) && !n_ov;
            if (accept_m) m_pending <= aes_ref(din, dkey);
            if (!accept_m && m_left == 1) m_out <= m_pending;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk1("cyc_in_ready", in_ready, m_ir);
        chk1("cyc_out_valid", out_valid, m_ov);
        chk1("cyc_busy", busy, (m_left != 0) || m_ov);
        check("cyc_out", dout, m_out);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk1("wait_in_ready", in_ready, 1'b1);
    endtask

    // Present one block, optionally churn inputs during RUN, return cycles from accept to out_valid
    task automatic send(input logic [127:0] p, input logic [127:0] k, input bit churn, output int lat);
        wait_ready();
        in_valid = 1'b1;
        din      = p;
        dkey     = k;
        tick();
        in_valid = 1'b0;
        lat      = -1;
        for (int n = 1; n <= 40; n++) begin
            if (churn) begin
                din      = {$urandom, $urandom, $urandom, $urandom};
                dkey     = {$urandom, $urandom, $urandom, $urandom};
                in_valid = ($urandom_range(0, 1) == 1);
            end
            tick();
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   p, q;
        int           lat;
        int           acc_k[$];
        logic [127:0] outs[$];
        logic         acc;

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = 128'h0;
        dkey      = 128'h0;

        // S-box table from the generator-3 walk of GF(2^8)
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            sb[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
        end
        sb[0] = 8'h63;

        // Pin the reference model to hand-known values
        check("model_sbox_00", {120'h0, sb[8'h00]}, 128'h63);
        check("model_sbox_53", {120'h0, sb[8'h53]}, 128'hed);
        check("model_app_b", aes_ref(PT_B, KEY_B), CT_B);
        check("model_app_c1", aes_ref(PT_C, KEY_C), CT_C);

        repeat (3) tick();
        check("rst_out", dout, 128'h0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        reset = 1'b1;
        tick();
        chk1("rst_in_ready_after", in_ready, 1'b1);

        // App B with 20 cycles of backpressure
        send(PT_B, KEY_B, 1'b0, lat);
        check("app_b_latency", 128'(lat), 128'd10);
        check("app_b_out", dout, CT_B);
        for (int n = 0; n < 20; n++) begin
            tick();
            check("bp_out", dout, CT_B);
            chk1("bp_out_valid", out_valid, 1'b1);
            chk1("bp_in_ready", in_ready, 1'b0);
        end
        release_out();
        chk1("handoff_out_valid", out_valid, 1'b0);
        chk1("handoff_in_ready", in_ready, 1'b1);
        check("handoff_out_retained", dout, CT_B);

        // App C.1
        send(PT_C, KEY_C, 1'b0, lat);
        check("app_c1_latency", 128'(lat), 128'd10);
        check("app_c1_out", dout, CT_C);
        release_out();

        // Input churn during RUN must not disturb the block
        send(PT_B, KEY_B, 1'b1, lat);
        check("churn_latency", 128'(lat), 128'd10);
        check("churn_out", dout, CT_B);
        release_out();

        // Reset pulse at round 5
        wait_ready();
        in_valid = 1'b1;
        din      = PT_B;
        dkey     = KEY_B;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        #1;
        reset = 1'b0;
        #1;
        check("midrst_out", dout, 128'h0);
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk1("midrst_in_ready", in_ready, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        send(PT_C, KEY_C, 1'b0, lat);
        check("midrst_c1_latency", 128'(lat), 128'd10);
        check("midrst_c1_out", dout, CT_C);
        release_out();

        // Back-to-back: in_valid held high, out_ready held high
        wait_ready();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        din       = PT_B;
        dkey      = KEY_B;
        for (int k = 1; k <= 26; k++) begin
            acc = in_valid && in_ready;
            tick();
            if (out_valid) outs.push_back(dout);
            if (acc) begin
                acc_k.push_back(k);
                if (acc_k.size() == 1) begin
                    din  = PT_C;
                    dkey = KEY_C;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_accept_count", 128'(acc_k.size()), 128'd2);
        check("b2b_output_count", 128'(outs.size()), 128'd2);
        if (acc_k.size() >= 2) check("b2b_spacing", 128'(acc_k[1] - acc_k[0]), 128'd12);
        else chk1("b2b_spacing_present", 1'b0, 1'b1);
        if (outs.size() >= 2) begin
            check("b2b_first_out", outs[0], CT_B);
            check("b2b_second_out", outs[1], CT_C);
        end else begin
            chk1("b2b_outputs_present", 1'b0, 1'b1);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 1200; n++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 2) == 0);
            din       = {$urandom, $urandom, $urandom, $urandom};
            dkey      = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (15) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
